// File: rtl/ppu_ri_sync.sv
// ppu_ri_sync: CPU-side PPU register file ($2000-$2007).
// Owns the VRAM pointer v, the OAM pointer and the shared write toggle w.
// Runs buffered $2007 VRAM accesses through an IDLE/VACC/VCAP FSM with a
// busy/ack handshake.
// Optional macro PPU_RI_PAL_DIRECT_EN: $2007 reads at v >= PAL_BASE return
// VRAM data directly rather than the stale read buffer.
`timescale 1ns/1ps
module ppu_ri_sync #(
  parameter int VRAM_AW  = 14,
  parameter int OAM_AW   = 8,
  parameter int INC_ALT  = 32,
  parameter int PAL_BASE = 'h3F00
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               ri_en_in,
  input  logic [2:0]         ri_sel_in,
  input  logic               ri_wr_in,
  input  logic [7:0]         ri_data_in,
  output logic [7:0]         ri_data_out,
  output logic               ri_ack_out,
  output logic               ri_busy_out,
  input  logic               vblank_set_in,
  input  logic               vblank_clr_in,
  input  logic               spr0_hit_in,
  input  logic               spr_ovf_in,
  output logic [VRAM_AW-1:0] vram_addr_out,
  output logic               vram_en_out,
  output logic               vram_wr_out,
  output logic [7:0]         vram_data_out,
  input  logic [7:0]         vram_data_in,
  output logic [OAM_AW-1:0]  oam_addr_out,
  output logic               oam_wr_out,
  output logic [7:0]         oam_data_out,
  input  logic [7:0]         oam_data_in,
  output logic [7:0]         ctrl_out,
  output logic [7:0]         mask_out,
  output logic [7:0]         scr_x_out,
  output logic [7:0]         scr_y_out,
  output logic               nmi_out
);

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  typedef enum logic [1:0] {IDLE, VACC, VCAP} state_t;

  // Pending $2007 request, latched when the strobe is accepted.
  typedef struct packed {
    logic       wr;
    logic [7:0] data;
  } ri_req_t;

  state_t              state, state_nx;
  ri_req_t             req;
  logic [VRAM_AW-1:0]  v, step;
  logic [OAM_AW-1:0]   oam_addr;
  logic [7:0]          rbuf;
  logic                w, vblank, oam_wr_q;
  logic                acc, rd_status;

`ifdef PPU_RI_PAL_DIRECT_EN
  localparam logic [VRAM_AW-1:0] PAL_V = VRAM_AW'(PAL_BASE);
`else
  logic unused_pal;
  assign unused_pal = ^PAL_BASE;
`endif

  // Strobes are only taken while IDLE; anything arriving while busy is dropped.
  assign acc       = ri_en_in && (state == IDLE);
  assign rd_status = acc && !ri_wr_in && (ri_sel_in == REG_STATUS);
  assign step      = ctrl_out[2] ? VRAM_AW'(INC_ALT) : VRAM_AW'(1);

  assign ri_busy_out   = (state != IDLE);
  assign vram_addr_out = v;
  assign vram_en_out   = (state == VACC);
  assign vram_wr_out   = (state == VACC) && req.wr;
  assign vram_data_out = req.data;
  assign oam_addr_out  = oam_addr;
  assign oam_wr_out    = oam_wr_q;
  assign nmi_out       = ctrl_out[7] & vblank;

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: a write finishes after VACC, a read also needs VCAP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc && ri_sel_in == REG_DATA) state_nx = VACC;
      VACC:    state_nx = req.wr ? IDLE : VCAP;
      VCAP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Register file, pointers, read buffer, vblank flag and handshake.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ri_data_out  <= '0;
      ri_ack_out   <= 1'b0;
      ctrl_out     <= '0;
      mask_out     <= '0;
      scr_x_out    <= '0;
      scr_y_out    <= '0;
      oam_data_out <= '0;
      oam_wr_q     <= 1'b0;
      oam_addr     <= '0;
      v            <= '0;
      w            <= 1'b0;
      rbuf         <= '0;
      vblank       <= 1'b0;
      req          <= '0;
    end else begin
      ri_ack_out <= 1'b0;
      oam_wr_q   <= 1'b0;
      // Post-increment after the OAM write pulse; a $2003 write below wins.
      if (oam_wr_q) oam_addr <= oam_addr + OAM_AW'(1);
      // Set beats clear; a status read samples the pre-edge value.
      if (vblank_set_in)                   vblank <= 1'b1;
      else if (vblank_clr_in || rd_status) vblank <= 1'b0;

      if (acc) begin
        if (ri_sel_in != REG_DATA) ri_ack_out <= 1'b1;
        if (ri_wr_in) begin
          case (ri_sel_in)
            REG_CTRL:    ctrl_out <= ri_data_in;
            REG_MASK:    mask_out <= ri_data_in;
            REG_OAMADDR: oam_addr <= OAM_AW'(ri_data_in);
            REG_OAMDATA: begin
              oam_wr_q     <= 1'b1;
              oam_data_out <= ri_data_in;
            end
            REG_SCROLL: begin
              if (!w) scr_x_out <= ri_data_in;
              else    scr_y_out <= ri_data_in;
              w <= ~w;
            end
            REG_ADDR: begin
              if (!w) v[VRAM_AW-1:8] <= ri_data_in[VRAM_AW-9:0];
              else    v[7:0]         <= ri_data_in;
              w <= ~w;
            end
            REG_DATA: req <= '{wr: 1'b1, data: ri_data_in};
            default: ;
          endcase
        end else begin
          case (ri_sel_in)
            REG_STATUS: begin
              ri_data_out <= {vblank, spr0_hit_in, spr_ovf_in, 5'b0};
              w           <= 1'b0;
            end
            REG_OAMDATA: ri_data_out <= oam_data_in;
            REG_DATA: begin
              ri_data_out <= rbuf;
              req.wr      <= 1'b0;
            end
            default: ri_data_out <= '0;
          endcase
        end
      end

      if (state == VACC && req.wr) begin
        v          <= v + step;
        ri_ack_out <= 1'b1;
      end

      if (state == VCAP) begin
        rbuf       <= vram_data_in;
        v          <= v + step;
        ri_ack_out <= 1'b1;
`ifdef PPU_RI_PAL_DIRECT_EN
        if (v >= PAL_V) ri_data_out <= vram_data_in;
`endif
      end
    end
  end

endmodule
